// File: rtl/io_controller_if.sv
// Character I/O bundle between keyboard/display pins, CPU control unit and io_controller.
// Latency: none, wires only.
// Backpressure: none; master drives strobes and data, slave returns registers and flags.
interface io_controller_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] key_data;
  logic              key_strobe;
  logic              inp_ack;
  logic              out_load;
  logic [DATA_W-1:0] ac_low;
  logic              ien_set;
  logic              ien_clr;
  logic              int_ack;
  logic [DATA_W-1:0] inpr;
  logic              fgi;
  logic              overrun;
  logic [DATA_W-1:0] outr;
  logic              fgo;
  logic              display_strobe;
  logic              ien;
  logic              int_req;

  modport master (
    output key_data, key_strobe, inp_ack, out_load, ac_low, ien_set, ien_clr, int_ack,
    input  inpr, fgi, overrun, outr, fgo, display_strobe, ien, int_req
  );

  modport slave (
    input  key_data, key_strobe, inp_ack, out_load, ac_low, ien_set, ien_clr, int_ack,
    output inpr, fgi, overrun, outr, fgo, display_strobe, ien, int_req
  );
endinterface

// File: rtl/io_controller.sv
// Keyboard/display character sequencer: INPR/FGI capture, OUTR pacing with FGO, interrupt request R.
// Latency: key_strobe rise to fgi in 3 edges; out_load to display_strobe in OUT_BUSY_CYCLES edges.
// Backpressure: none; CPU polls fgi/fgo, chars arriving while fgi=1 are dropped (overrun), busy loads ignored.
module io_controller #(
  parameter int DATA_W          = 8,
  parameter int OUT_BUSY_CYCLES = 16
) (
  input logic           clk,
  input logic           reset,
  io_controller_if.slave io
);

  localparam logic [7:0] BUSY_INIT = 8'(OUT_BUSY_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } out_state_t;

  logic              s1, s2, s3;
  logic              key_edge;

  logic [DATA_W-1:0] inpr_q, inpr_d;
  logic              fgi_q, fgi_d;
  logic              ovr_q, ovr_d;

  out_state_t        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] outr_q, outr_d;
  logic              fgo;
  logic              disp_stb;

  logic              ien_q, ien_d;
  logic              req_q, req_d;

  // key_strobe is asynchronous: two flops for metastability, third for edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= io.key_strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign key_edge = s2 & ~s3;

  // An ack in the same cycle as a new char consumes the old one, so the new one loads cleanly
  always_comb begin
    inpr_d = inpr_q;
    fgi_d  = fgi_q;
    ovr_d  = ovr_q;
    if (key_edge) begin
      if (!fgi_q || io.inp_ack) begin
        inpr_d = io.key_data;
        fgi_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (io.inp_ack && fgi_q) begin
      fgi_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inpr_q <= '0;
      fgi_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      inpr_q <= inpr_d;
      fgi_q  <= fgi_d;
      ovr_q  <= ovr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      outr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      outr_q  <= outr_d;
    end
  end

  // fgo is decoded from state so an async reset restores it without a clock
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    outr_d   = outr_q;
    fgo      = 1'b0;
    disp_stb = 1'b0;
    case (state_q)
      IDLE: begin
        fgo = 1'b1;
        if (io.out_load) begin
          outr_d  = io.ac_low;
          cnt_d   = BUSY_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        disp_stb = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // int_ack beats everything; R is sticky until acknowledged
  always_comb begin
    ien_d = ien_q;
    req_d = req_q;
    if (io.int_ack) begin
      ien_d = 1'b0;
      req_d = 1'b0;
    end else begin
      if (io.ien_clr) begin
        ien_d = 1'b0;
      end else if (io.ien_set) begin
        ien_d = 1'b1;
      end
      if (ien_q && (fgi_q || fgo)) begin
        req_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ien_q <= 1'b0;
      req_q <= 1'b0;
    end else begin
      ien_q <= ien_d;
      req_q <= req_d;
    end
  end

  assign io.inpr           = inpr_q;
  assign io.fgi            = fgi_q;
  assign io.overrun        = ovr_q;
  assign io.outr           = outr_q;
  assign io.fgo            = fgo;
  assign io.display_strobe = disp_stb;
  assign io.ien            = ien_q;
  assign io.int_req        = req_q;

endmodule

// File: tb/tb_io_controller.sv
// Scoreboarded random + directed bench for io_controller against a transaction-level model.
module tb_io_controller;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  io_controller_if #(.DATA_W(8)) io();

  io_controller #(.DATA_W(8), .OUT_BUSY_CYCLES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state: registers as seen after edge number cyc
  logic [7:0] m_inpr, m_outr;
  logic       m_fgi, m_ovr, m_ien, m_req;
  int         m_load;
  int         key_timer;

  int         pend_edge[$];
  logic [7:0] pend_dat[$];
  logic [21:0] st_q[$];
  logic       rd_fgi_q[$];
  logic [7:0] rd_dat_q[$];
  logic [7:0] disp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // display busy window: from the load edge up to and including the strobe edge
  function automatic logic fgo_at(input int c);
    return !(c >= m_load && c <= m_load + N);
  endfunction

  task automatic model_reset();
    m_inpr = 8'h00; m_outr = 8'h00;
    m_fgi = 1'b0; m_ovr = 1'b0; m_ien = 1'b0; m_req = 1'b0;
    m_load = -1000;
    pend_edge.delete(); pend_dat.delete();
  endtask

  task automatic step();
    int e;
    logic key;
    logic [7:0] kd;
    logic [7:0] n_inpr, n_outr;
    logic n_fgi, n_ovr, n_ien, n_req;
    int n_load;
    e = cyc + 1;
    key = 1'b0;
    kd = 8'h00;
    if (pend_edge.size() > 0 && pend_edge[0] == e) begin
      key = 1'b1;
      kd = pend_dat.pop_front();
      void'(pend_edge.pop_front());
    end
    n_inpr = m_inpr; n_fgi = m_fgi; n_ovr = m_ovr;
    n_outr = m_outr; n_load = m_load; n_ien = m_ien; n_req = m_req;
    if (key) begin
      if (!m_fgi || io.inp_ack) begin
        n_inpr = kd;
        n_fgi = 1'b1;
      end else begin
        n_ovr = 1'b1;
      end
    end else if (io.inp_ack && m_fgi) begin
      n_fgi = 1'b0;
      n_ovr = 1'b0;
    end
    if (io.inp_ack) begin
      rd_fgi_q.push_back(m_fgi);
      rd_dat_q.push_back(m_inpr);
    end
    if (io.out_load && fgo_at(cyc)) begin
      n_load = e;
      n_outr = io.ac_low;
      disp_q.push_back(io.ac_low);
    end
    if (io.int_ack) begin
      n_ien = 1'b0;
      n_req = 1'b0;
    end else begin
      if (io.ien_clr) n_ien = 1'b0;
      else if (io.ien_set) n_ien = 1'b1;
      if (m_ien && (m_fgi || fgo_at(cyc))) n_req = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc = e;
    m_inpr = n_inpr; m_fgi = n_fgi; m_ovr = n_ovr;
    m_outr = n_outr; m_load = n_load; m_ien = n_ien; m_req = n_req;
    st_q.push_back({m_inpr, m_fgi, m_ovr, m_outr, fgo_at(cyc), m_ien, m_req, (cyc == m_load + N)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_inputs();
    io.inp_ack = 1'b0; io.out_load = 1'b0; io.ac_low = 8'h00;
    io.ien_set = 1'b0; io.ien_clr = 1'b0; io.int_ack = 1'b0;
  endtask

  // strobe high for three samples; char lands on the third edge
  task automatic key_press(input logic [7:0] d, input logic ack_on_edge);
    io.key_data = d;
    io.key_strobe = 1'b1;
    pend_edge.push_back(cyc + 3);
    pend_dat.push_back(d);
    step();
    step();
    io.inp_ack = ack_on_edge;
    step();
    io.inp_ack = 1'b0;
    io.key_strobe = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    logic [21:0] ex;
    logic [21:0] act;
    act = {io.inpr, io.fgi, io.overrun, io.outr, io.fgo, io.ien, io.int_req, io.display_strobe};
    if (st_q.size() > 0) begin
      ex = st_q.pop_front();
      chk("status{inpr,fgi,ovr,outr,fgo,ien,req,stb}", 32'(act), 32'(ex));
    end
    if (io.inp_ack && rd_fgi_q.size() > 0) begin
      chk("read_fgi", 32'(io.fgi), 32'(rd_fgi_q.pop_front()));
      chk("read_inpr", 32'(io.inpr), 32'(rd_dat_q.pop_front()));
    end
    if (io.display_strobe) begin
      if (disp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL display_unexpected actual=strobe required=no strobe (cycle %0d)", cyc);
      end else begin
        chk("display_outr", 32'(io.outr), 32'(disp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0;
    io.key_data = 8'h00;
    io.key_strobe = 1'b0;
    clear_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;

    chk("reset_inpr", 32'(io.inpr), 32'h00);
    chk("reset_fgi", 32'(io.fgi), 32'h0);
    chk("reset_fgo", 32'(io.fgo), 32'h1);
    chk("reset_ien", 32'(io.ien), 32'h0);
    chk("reset_int_req", 32'(io.int_req), 32'h0);
    idle(4);

    // input path
    key_press(8'h41, 1'b0);
    chk("key1_inpr", 32'(io.inpr), 32'h41);
    chk("key1_fgi", 32'(io.fgi), 32'h1);
    idle(2);
    key_press(8'h42, 1'b0);
    chk("overrun_inpr_kept", 32'(io.inpr), 32'h41);
    chk("overrun_set", 32'(io.overrun), 32'h1);
    idle(2);
    io.inp_ack = 1'b1;
    step();
    io.inp_ack = 1'b0;
    chk("ack_fgi_clr", 32'(io.fgi), 32'h0);
    chk("ack_overrun_clr", 32'(io.overrun), 32'h0);
    io.inp_ack = 1'b1;
    step();
    io.inp_ack = 1'b0;
    chk("ack_idle_fgi", 32'(io.fgi), 32'h0);
    key_press(8'h41, 1'b0);
    idle(2);
    key_press(8'h43, 1'b1);
    chk("coincident_inpr", 32'(io.inpr), 32'h43);
    chk("coincident_fgi", 32'(io.fgi), 32'h1);
    chk("coincident_overrun", 32'(io.overrun), 32'h0);
    idle(2);
    io.inp_ack = 1'b1;
    step();
    io.inp_ack = 1'b0;

    // output path
    io.ac_low = 8'h5A;
    io.out_load = 1'b1;
    step();
    io.out_load = 1'b0;
    chk("load_outr", 32'(io.outr), 32'h5A);
    chk("load_fgo", 32'(io.fgo), 32'h0);
    idle(4);
    io.ac_low = 8'h33;
    io.out_load = 1'b1;
    step();
    io.out_load = 1'b0;
    chk("busy_load_ignored", 32'(io.outr), 32'h5A);
    idle(N + 2);
    chk("fgo_after_done", 32'(io.fgo), 32'h1);

    // interrupt
    io.ien_set = 1'b1;
    step();
    io.ien_set = 1'b0;
    chk("ien_set", 32'(io.ien), 32'h1);
    step();
    chk("int_req_rise", 32'(io.int_req), 32'h1);
    io.int_ack = 1'b1;
    step();
    io.int_ack = 1'b0;
    chk("int_ack_req", 32'(io.int_req), 32'h0);
    chk("int_ack_ien", 32'(io.ien), 32'h0);
    io.ien_set = 1'b1;
    io.ien_clr = 1'b1;
    step();
    clear_inputs();
    chk("ien_clr_wins", 32'(io.ien), 32'h0);

    // asynchronous reset while the display is busy
    io.ac_low = 8'h77;
    io.out_load = 1'b1;
    step();
    io.out_load = 1'b0;
    idle(3);
    st_q.delete(); rd_fgi_q.delete(); rd_dat_q.delete(); disp_q.delete();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_fgo", 32'(io.fgo), 32'h1);
    chk("async_rst_outr", 32'(io.outr), 32'h00);
    chk("async_rst_strobe", 32'(io.display_strobe), 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    cyc = cyc + 4;
    idle(N + 5);
    chk("post_reset_fgo", 32'(io.fgo), 32'h1);

    // randomized traffic
    key_timer = 2;
    for (int i = 0; i < 1500; i++) begin
      if (key_timer == 0) begin
        if (io.key_strobe) begin
          io.key_strobe = 1'b0;
          key_timer = $urandom_range(1, 5);
        end else begin
          io.key_data = 8'($urandom);
          io.key_strobe = 1'b1;
          pend_edge.push_back(cyc + 3);
          pend_dat.push_back(io.key_data);
          key_timer = $urandom_range(1, 3);
        end
      end else begin
        key_timer--;
      end
      io.inp_ack  = ($urandom_range(0, 5) == 0);
      io.out_load = ($urandom_range(0, 7) == 0);
      io.ac_low   = 8'($urandom);
      io.ien_set  = ($urandom_range(0, 15) == 0);
      io.ien_clr  = ($urandom_range(0, 31) == 0);
      io.int_ack  = ($urandom_range(0, 11) == 0);
      step();
    end

    clear_inputs();
    io.key_strobe = 1'b0;
    idle(N + 10);
    @(negedge clk);
    #1;
    chk("drain_display_queue", 32'(disp_q.size()), 32'd0);
    chk("drain_status_queue", 32'(st_q.size()), 32'd0);
    chk("drain_key_events", 32'(pend_edge.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
